// File: rtl/ifu_cache_ctrl.sv
// Sequencing controller for the IFU fully-associative instruction cache.
// Owns the tag/valid/data arrays; PLRU state lives in an external instance.
module ifu_cache_ctrl #(
    parameter  int WAYS_NUM = 16,
    parameter  int ADDR_W   = 32,
    parameter  int LINE_W   = 128,
    localparam int WAY_W    = $clog2(WAYS_NUM),
    localparam int OFFS_W   = $clog2(LINE_W / 8),
    localparam int TAG_W    = ADDR_W - OFFS_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req_valid,
    input  logic [ADDR_W-1:0] i_cpu_req_addr,
    output logic              o_cpu_req_ready,
    output logic              o_cpu_rsp_valid,
    output logic [LINE_W-1:0] o_cpu_rsp_data,
    input  logic              i_flush,
    output logic              o_mem_req_valid,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    input  logic              i_mem_req_ready,
    input  logic              i_mem_rsp_valid,
    input  logic [LINE_W-1:0] i_mem_rsp_data,
    output logic              o_plru_update_tree,
    output logic              o_plru_cache_miss,
    output logic [WAY_W-1:0]  o_plru_hit_cl,
    input  logic [WAY_W-1:0]  i_plru_evicted_cl,
    output logic [31:0]       o_hit_cnt,
    output logic [31:0]       o_miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_FILL
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WAYS_NUM-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [WAYS_NUM];
    logic [LINE_W-1:0]   r_data [WAYS_NUM];

    logic [TAG_W-1:0]    r_req_tag;
    logic [LINE_W-1:0]   r_fill_data;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;

    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_accept;
    logic                w_unused_offs;

    // The byte offset only selects a word inside the line, which fetch does itself.
    assign w_unused_offs = ^i_cpu_req_addr[OFFS_W-1:0];

    assign w_accept   = (r_state == S_IDLE) && !i_flush && i_cpu_req_valid;
    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;

    // Descending scan so the lowest matching way wins if duplicates ever appear.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = WAYS_NUM - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == r_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        o_cpu_req_ready    = 1'b0;
        o_cpu_rsp_valid    = 1'b0;
        o_cpu_rsp_data     = '0;
        o_mem_req_valid    = 1'b0;
        o_mem_req_addr     = '0;
        o_plru_update_tree = 1'b0;
        o_plru_cache_miss  = 1'b0;
        o_plru_hit_cl      = '0;

        case (r_state)
            S_IDLE: begin
                o_cpu_req_ready = !i_flush;
                if (w_accept) begin
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    o_cpu_rsp_valid    = 1'b1;
                    o_cpu_rsp_data     = r_data[w_hit_way];
                    o_plru_update_tree = 1'b1;
                    o_plru_hit_cl      = w_hit_way;
                    w_state_next       = S_IDLE;
                end else begin
                    w_state_next = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = {r_req_tag, {OFFS_W{1'b0}}};
                if (i_mem_req_ready) begin
                    w_state_next = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (i_mem_rsp_valid) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                o_plru_update_tree = 1'b1;
                o_plru_cache_miss  = 1'b1;
                o_cpu_rsp_valid    = 1'b1;
                o_cpu_rsp_data     = r_fill_data;
                w_state_next       = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == S_IDLE) && i_flush) begin
                r_valid <= '0;
            end else if (r_state == S_FILL) begin
                r_valid[i_plru_evicted_cl] <= 1'b1;
            end

            // Counters stick at all-ones rather than wrapping.
            if (r_state == S_LOOKUP) begin
                if (w_hit) begin
                    if (r_hit_cnt != 32'hFFFF_FFFF) begin
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                    end
                end else if (r_miss_cnt != 32'hFFFF_FFFF) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    // Arrays carry no reset; a reset simply suppresses any pending capture or fill.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_accept) begin
                r_req_tag <= i_cpu_req_addr[ADDR_W-1:OFFS_W];
            end
            if ((r_state == S_MEM_WAIT) && i_mem_rsp_valid) begin
                r_fill_data <= i_mem_rsp_data;
            end
            if (r_state == S_FILL) begin
                r_tag[i_plru_evicted_cl]  <= r_req_tag;
                r_data[i_plru_evicted_cl] <= r_fill_data;
            end
        end
    end

endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// Scoreboard bench for ifu_cache_ctrl: an LRU-ordered victim chooser stands in for the PLRU,
// and a per-way cache model predicts hits, misses, fill addresses and response data.
module tb_ifu_cache_ctrl;

    localparam int WAYS   = 16;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int WAY_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_cpu_req_valid = 1'b0;
    logic [ADDR_W-1:0] i_cpu_req_addr = '0;
    logic              o_cpu_req_ready;
    logic              o_cpu_rsp_valid;
    logic [LINE_W-1:0] o_cpu_rsp_data;
    logic              i_flush = 1'b0;
    logic              o_mem_req_valid;
    logic [ADDR_W-1:0] o_mem_req_addr;
    logic              i_mem_req_ready = 1'b0;
    logic              i_mem_rsp_valid = 1'b0;
    logic [LINE_W-1:0] i_mem_rsp_data = '0;
    logic              o_plru_update_tree;
    logic              o_plru_cache_miss;
    logic [WAY_W-1:0]  o_plru_hit_cl;
    logic [WAY_W-1:0]  i_plru_evicted_cl = '0;
    logic [31:0]       o_hit_cnt;
    logic [31:0]       o_miss_cnt;

    always #5 clk = ~clk;

    ifu_cache_ctrl dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_cpu_req_valid    (i_cpu_req_valid),
        .i_cpu_req_addr     (i_cpu_req_addr),
        .o_cpu_req_ready    (o_cpu_req_ready),
        .o_cpu_rsp_valid    (o_cpu_rsp_valid),
        .o_cpu_rsp_data     (o_cpu_rsp_data),
        .i_flush            (i_flush),
        .o_mem_req_valid    (o_mem_req_valid),
        .o_mem_req_addr     (o_mem_req_addr),
        .i_mem_req_ready    (i_mem_req_ready),
        .i_mem_rsp_valid    (i_mem_rsp_valid),
        .i_mem_rsp_data     (i_mem_rsp_data),
        .o_plru_update_tree (o_plru_update_tree),
        .o_plru_cache_miss  (o_plru_cache_miss),
        .o_plru_hit_cl      (o_plru_hit_cl),
        .i_plru_evicted_cl  (i_plru_evicted_cl),
        .o_hit_cnt          (o_hit_cnt),
        .o_miss_cnt         (o_miss_cnt)
    );

    typedef struct {
        logic [LINE_W-1:0] data;
        bit                miss;
        int                way;
        int                cyc;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    int          lruQ[$];
    int          plruWay;
    bit          modelValid [WAYS];
    logic [27:0] modelTag   [WAYS];
    logic [127:0] modelData [WAYS];
    int unsigned modelHits   = 0;
    int unsigned modelMisses = 0;
    int          checks      = 0;
    int          errors      = 0;
    int          cycleCount  = 0;
    int unsigned abortSeq    = 0;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Victim chooser: least recently touched way first; touched ways move to the back.
    always @(posedge clk) begin
        if (!rst && o_plru_update_tree) begin
            plruWay = o_plru_cache_miss ? int'(i_plru_evicted_cl) : int'(o_plru_hit_cl);
            #1;
            for (int i = 0; i < lruQ.size(); i++) begin
                if (lruQ[i] == plruWay) begin
                    lruQ.delete(i);
                    break;
                end
            end
            lruQ.push_back(plruWay);
            i_plru_evicted_cl = WAY_W'(lruQ[0]);
        end
    end

    // Monitor: every response pops one expectation; quiet cycles must keep PLRU strobes low.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_cpu_rsp_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 data=%0h, expected none (t=%0t)",
                             o_cpu_rsp_data, $time);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("rsp_data", o_cpu_rsp_data, monE.data);
                    checkOutput("plru_update_tree", 128'(o_plru_update_tree), 128'd1);
                    checkOutput("plru_cache_miss", 128'(o_plru_cache_miss), 128'(monE.miss));
                    checkOutput("plru_hit_cl", 128'(o_plru_hit_cl), monE.miss ? 128'd0 : 128'(monE.way));
                    if (!monE.miss) checkOutput("hit_latency", 128'(cycleCount), 128'(monE.cyc));
                end
            end else begin
                checkOutput("plru_idle_strobes",
                            128'({o_plru_update_tree, o_plru_cache_miss, o_plru_hit_cl}), 128'd0);
            end
        end
    end

    function automatic int findWay(input logic [27:0] tag);
        for (int i = 0; i < WAYS; i++) begin
            if (modelValid[i] && modelTag[i] == tag) return i;
        end
        return -1;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < WAYS; i++) modelValid[i] = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!o_cpu_req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready", 128'(o_cpu_req_ready), 128'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL rsp_timeout: got %0d responses pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkCounters();
        @(negedge clk);
        checkOutput("hit_cnt", 128'(o_hit_cnt), 128'(modelHits));
        checkOutput("miss_cnt", 128'(o_miss_cnt), 128'(modelMisses));
    endtask

    // One fetch transaction; on a miss it also plays the memory side of the line fill.
    task automatic applyStimulus(input logic [31:0] addr, input int readyDelay,
                                 input bit strayRsp, input bit abortInWait);
        logic [27:0]  tag;
        logic [127:0] fillData;
        int           way;
        int           victim;
        int           n;
        int           accCyc;
        tag = addr[31:4];
        way = findWay(tag);
        waitReady();
        @(posedge clk); #1;
        i_cpu_req_valid = 1'b1;
        i_cpu_req_addr  = addr;
        i_mem_req_ready = (way < 0) && (readyDelay == 0);
        @(posedge clk); #1;
        accCyc = cycleCount;
        i_cpu_req_valid = 1'b0;
        if (way >= 0) begin
            modelHits++;
            expQ.push_back('{data: modelData[way], miss: 1'b0, way: way, cyc: accCyc});
            waitDrain();
            return;
        end
        modelMisses++;
        victim   = lruQ[0];
        fillData = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (!abortInWait) begin
            expQ.push_back('{data: fillData, miss: 1'b1, way: victim, cyc: -1});
            modelValid[victim] = 1'b1;
            modelTag[victim]   = tag;
            modelData[victim]  = fillData;
        end
        n = 0;
        @(negedge clk);
        while (!o_mem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mem_req_valid", 128'(o_mem_req_valid), 128'd1);
        checkOutput("mem_req_addr", 128'(o_mem_req_addr), 128'({tag, 4'h0}));
        for (int i = 1; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput("mem_req_valid_hold", 128'(o_mem_req_valid), 128'd1);
            checkOutput("mem_req_addr_hold", 128'(o_mem_req_addr), 128'({tag, 4'h0}));
            checkOutput("no_rsp_before_fill", 128'(o_cpu_rsp_valid), 128'd0);
            if (strayRsp && i == 1) begin
                i_mem_rsp_valid = 1'b1;
                i_mem_rsp_data  = ~fillData;
            end else begin
                i_mem_rsp_valid = 1'b0;
            end
        end
        if (readyDelay > 0) begin
            @(posedge clk); #1;
            i_mem_rsp_valid = 1'b0;
            i_mem_req_ready = 1'b1;
        end
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
        @(negedge clk);
        checkOutput("mem_req_drop", 128'(o_mem_req_valid), 128'd0);
        if (abortInWait) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst             = 1'b0;
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = fillData;
            @(posedge clk); #1;
            i_mem_rsp_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkOutput("abort_no_rsp", 128'(o_cpu_rsp_valid), 128'd0);
                checkOutput("abort_no_mem_req", 128'(o_mem_req_valid), 128'd0);
            end
            clearModel();
            modelHits   = 0;
            modelMisses = 0;
            checkCounters();
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = fillData;
        @(posedge clk); #1;
        i_mem_rsp_valid = 1'b0;
        waitDrain();
    endtask

    task automatic applyFlush(input logic [31:0] addr, input bit withReq);
        waitReady();
        @(posedge clk); #1;
        i_flush         = 1'b1;
        i_cpu_req_valid = withReq;
        i_cpu_req_addr  = addr;
        @(negedge clk);
        checkOutput("ready_during_flush", 128'(o_cpu_req_ready), 128'd0);
        @(posedge clk); #1;
        i_flush         = 1'b0;
        i_cpu_req_valid = 1'b0;
        clearModel();
        @(negedge clk);
        checkOutput("ready_after_flush", 128'(o_cpu_req_ready), 128'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pool [24];
        int          r;
        int          d;
        for (int i = 0; i < WAYS; i++) lruQ.push_back(i);
        clearModel();
        for (int i = 0; i < 24; i++) pool[i] = 32'h8000_0000 + 32'(i) * 32'h40;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 128'(o_cpu_req_ready), 128'd1);
        checkOutput("reset_rsp_valid", 128'(o_cpu_rsp_valid), 128'd0);
        checkOutput("reset_rsp_data", o_cpu_rsp_data, 128'd0);
        checkOutput("reset_mem_req", 128'({o_mem_req_valid, o_mem_req_addr}), 128'd0);
        checkOutput("reset_plru", 128'({o_plru_update_tree, o_plru_cache_miss, o_plru_hit_cl}), 128'd0);
        checkOutput("reset_counters", 128'({o_hit_cnt, o_miss_cnt}), 128'd0);

        $display("[TB] cold miss then hit on the same line");
        applyStimulus(32'h0000_1000, 0, 1'b0, 1'b0);
        applyStimulus(32'h0000_1004, 0, 1'b0, 1'b0);
        checkCounters();

        $display("[TB] memory ready held low with a stray response");
        applyStimulus(32'h0000_2000, 5, 1'b1, 1'b0);

        $display("[TB] seventeen distinct cold lines then line-0 re-request");
        applyFlush(32'h0, 1'b0);
        for (int i = 0; i < 17; i++) applyStimulus(32'h0010_0000 + 32'(i) * 32'h10, i % 3, 1'b0, 1'b0);
        applyStimulus(32'h0010_0008, 1, 1'b0, 1'b0);
        checkCounters();

        $display("[TB] flush colliding with a request");
        applyStimulus(32'h0000_3000, 0, 1'b0, 1'b0);
        applyFlush(32'h0000_3000, 1'b1);
        applyStimulus(32'h0000_3000, 2, 1'b0, 1'b0);
        checkCounters();

        $display("[TB] reset while waiting for fill data");
        applyStimulus(32'h0000_4000, 1, 1'b0, 1'b1);
        applyStimulus(32'h0000_1000, 0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 160; k++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 4);
            if (r < 4) begin
                applyFlush(pool[$urandom_range(0, 23)], r < 2);
            end else if (r < 6) begin
                abortSeq++;
                applyStimulus(32'hF000_0000 + abortSeq * 32'h10, d, 1'b0, 1'b1);
            end else begin
                applyStimulus(pool[$urandom_range(0, 23)] + 32'($urandom_range(0, 15)), d,
                              (d >= 2) && ($urandom_range(0, 1) == 1), 1'b0);
            end
        end
        checkCounters();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
